// File: rtl/spi_seq_pkg.sv
// ---------------------------------------------------------------------------
// spi_seq_pkg
// Shared definitions for the SPI command sequencer:
//   - seq_state_t   : sequencer FSM state encoding
//   - cmd_width()   : width of one queued command record {chan, data, rd}
//   - onehot_decode : channel index -> one-hot chip-select request
// No ports (package).
// ---------------------------------------------------------------------------
package spi_seq_pkg;

    // Upper bound on chip selects the one-hot decoder can produce.
    localparam int MAX_CHANNEL = 256;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_CS_LOW  = 3'd2,
        ST_CS_HIGH = 3'd3,
        ST_RSP     = 3'd4,
        ST_GAP     = 3'd5
    } seq_state_t;

    // Command record is {channel index, data word, read flag}.
    function automatic int cmd_width(input int chan_w, input int reg_w);
        return chan_w + reg_w + 1;
    endfunction

    // Callers size-cast the result down to their own channel count.
    function automatic logic [MAX_CHANNEL-1:0] onehot_decode(input logic [7:0] idx);
        logic [MAX_CHANNEL-1:0] vec;
        vec = MAX_CHANNEL'(1) << idx;
        return vec;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with full/empty flags and same-cycle push/pop.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, din       write strobe and data (ignored when full unless popping)
//   pop, dout       read strobe and head data (dout shows din when empty)
//   full, empty     occupancy flags
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             bypass;
    logic             do_write;
    logic             do_read;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // When empty the incoming word is presented directly so a simultaneous
    // push/pop passes straight through without touching storage.
    assign dout  = empty ? din : mem[rd_ptr];

    // Decide which side actually moves this cycle; at full a pop frees the
    // slot being written, at empty a push/pop pair is a pure pass-through.
    always_comb begin
        bypass   = push && pop && empty;
        do_write = push && (!full || pop) && !bypass;
        do_read  = pop && !empty;
    end

    // Storage array, no reset needed on the data itself.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_write && !do_read) begin
                count <= count + 1'b1;
            end else if (do_read && !do_write) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// spi_cmd_sequencer
// Buffers SPI commands and hands them one at a time to spi_master_core,
// watching the master's chip-select bus to find the end of each transfer and
// returning the captured MISO word on a valid/ready response port.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready               command push handshake (ready = FIFO not full)
//   cmd_chan, cmd_data, cmd_rd        channel index, word to send, want response
//   rsp_valid/rsp_ready               response handshake
//   rsp_data, rsp_chan, rsp_tmo       captured word, channel, timeout flag
//   wr_valid/wr_ready                 request to / accept pulse from the master
//   wr_channel, data_in               one-hot chip-select request, word to send
//   data_out                          master's received word
//   spi_cs                            monitored active-low chip selects
//   busy                              FSM active or commands pending
// ---------------------------------------------------------------------------
module spi_cmd_sequencer #(
    parameter int CHANNEL    = 8,
    parameter int REG_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CS_GAP     = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [$clog2(CHANNEL)-1:0] cmd_chan,
    input  logic [REG_WIDTH-1:0]       cmd_data,
    input  logic                       cmd_rd,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [REG_WIDTH-1:0]       rsp_data,
    output logic [$clog2(CHANNEL)-1:0] rsp_chan,
    output logic                       rsp_tmo,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [CHANNEL-1:0]         wr_channel,
    output logic [REG_WIDTH-1:0]       data_in,
    input  logic [REG_WIDTH-1:0]       data_out,
    input  logic [CHANNEL-1:0]         spi_cs,
    output logic                       busy
);

    import spi_seq_pkg::*;

    localparam int CW    = $clog2(CHANNEL);
    localparam int CMD_W = cmd_width(CW, REG_WIDTH);
    localparam int CNT_W = $clog2((TIMEOUT > CS_GAP) ? TIMEOUT : CS_GAP) + 1;

    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
    localparam logic [CW:0]      CHAN_LIMIT = (CW+1)'(CHANNEL);

    seq_state_t state;
    seq_state_t state_next;

    logic [CMD_W-1:0]     fifo_din;
    logic [CMD_W-1:0]     fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;

    logic [CW-1:0]        head_chan;
    logic [REG_WIDTH-1:0] head_data;
    logic                 head_rd;
    logic                 head_chan_ok;

    logic [CW-1:0]        hold_chan;
    logic [REG_WIDTH-1:0] hold_data;
    logic                 hold_rd;

    logic [CNT_W-1:0]     cnt;
    logic                 cnt_clear;
    logic                 load_hold;
    logic                 capture;
    logic                 timeout_hit;

    assign fifo_din  = {cmd_chan, cmd_data, cmd_rd};
    assign cmd_ready = !fifo_full;

    assign {head_chan, head_data, head_rd} = fifo_dout;
    // Indices past the last chip select are popped and silently dropped.
    assign head_chan_ok = ({1'b0, head_chan} < CHAN_LIMIT);

    assign busy = (state != ST_IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, master-side outputs and datapath strobes. The shared counter
    // is cleared on entry to CS_LOW (timeout window spans CS_LOW and CS_HIGH)
    // and on entry to GAP. wr_valid is purely a function of REQ, so it drops
    // on the same edge that samples wr_ready and is never seen again by the
    // master for this command.
    always_comb begin
        state_next  = state;
        fifo_pop    = 1'b0;
        load_hold   = 1'b0;
        cnt_clear   = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        wr_valid    = 1'b0;
        wr_channel  = '0;
        data_in     = '0;
        rsp_valid   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_chan_ok) begin
                        load_hold  = 1'b1;
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                wr_valid   = 1'b1;
                wr_channel = CHANNEL'(onehot_decode(8'(hold_chan)));
                data_in    = hold_data;
                if (wr_ready) begin
                    cnt_clear  = 1'b1;
                    state_next = ST_CS_LOW;
                end
            end
            ST_CS_LOW: begin
                if (cnt == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_RSP;
                end else if (spi_cs != '1) begin
                    state_next = ST_CS_HIGH;
                end
            end
            ST_CS_HIGH: begin
                // A clean completion on the final timeout cycle still counts.
                if (spi_cs == '1) begin
                    capture = 1'b1;
                    if (hold_rd) begin
                        state_next = ST_RSP;
                    end else begin
                        cnt_clear  = 1'b1;
                        state_next = ST_GAP;
                    end
                end else if (cnt == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    cnt_clear  = 1'b1;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Gap / timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clear) begin
            cnt <= '0;
        end else if (state == ST_CS_LOW || state == ST_CS_HIGH || state == ST_GAP) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Holding registers keep the popped command stable for the whole transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_chan <= '0;
            hold_data <= '0;
            hold_rd   <= 1'b0;
        end else if (load_hold) begin
            hold_chan <= head_chan;
            hold_data <= head_data;
            hold_rd   <= head_rd;
        end
    end

    // Response registers; a timeout reports a zero word with the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_chan <= '0;
            rsp_tmo  <= 1'b0;
        end else if (capture) begin
            rsp_data <= data_out;
            rsp_chan <= hold_chan;
            rsp_tmo  <= 1'b0;
        end else if (timeout_hit) begin
            rsp_data <= '0;
            rsp_chan <= hold_chan;
            rsp_tmo  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_spi_cmd_sequencer
// Directed bench for spi_cmd_sequencer with a behavioural stand-in for
// spi_master_core: it pulses wr_ready, drops the requested chip select for a
// fixed number of cycles and loops the sent word back on data_out when CS
// returns high. An accept-only mode never drops CS to provoke timeouts.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_cmd_sequencer;

    localparam int CHANNEL    = 8;
    localparam int REG_WIDTH  = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int CS_GAP     = 4;
    localparam int TIMEOUT    = 4096;
    localparam int XFER_CYC   = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_chan;
    logic [15:0] cmd_data;
    logic        cmd_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_chan;
    logic        rsp_tmo;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_channel;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [7:0]  spi_cs;
    logic        busy;

    bit          accept_only = 1'b0;
    int          checks;
    int          errors;

    int          m_state;
    int          m_cnt;
    logic [15:0] m_data;
    logic [7:0]  cs_log[$];
    logic [15:0] mosi_log[$];

    logic        wr_ready_d;
    logic        wr_ready_d2;
    logic        wr_valid_d;
    int          hi_cnt;
    int          proto_err = 0;
    int          gap_err   = 0;

    always #5 clk = ~clk;

    spi_cmd_sequencer #(
        .CHANNEL    (CHANNEL),
        .REG_WIDTH  (REG_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CS_GAP     (CS_GAP),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_chan   (cmd_chan),
        .cmd_data   (cmd_data),
        .cmd_rd     (cmd_rd),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_chan   (rsp_chan),
        .rsp_tmo    (rsp_tmo),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_channel (wr_channel),
        .data_in    (data_in),
        .data_out   (data_out),
        .spi_cs     (spi_cs),
        .busy       (busy)
    );

    // Master stand-in: accept, hold CS low, then loop the word back.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state  <= 0;
            m_cnt    <= 0;
            m_data   <= '0;
            wr_ready <= 1'b0;
            spi_cs   <= '1;
            data_out <= '0;
        end else begin
            case (m_state)
                0: begin
                    if (wr_valid) begin
                        wr_ready <= 1'b1;
                        m_state  <= 1;
                    end
                end
                1: begin
                    wr_ready <= 1'b0;
                    m_data   <= data_in;
                    if (accept_only) begin
                        m_state <= 0;
                    end else begin
                        spi_cs   <= ~wr_channel;
                        data_out <= '0;
                        m_cnt    <= 0;
                        m_state  <= 2;
                        cs_log.push_back(~wr_channel);
                        mosi_log.push_back(data_in);
                    end
                end
                default: begin
                    if (m_cnt == XFER_CYC - 1) begin
                        spi_cs   <= '1;
                        data_out <= m_data;
                        m_state  <= 0;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
            endcase
        end
    end

    // Protocol watchers: no wr_valid in the two cycles after a wr_ready
    // pulse, and at least CS_GAP cycles of CS high before a new request.
    always @(posedge clk) begin
        wr_ready_d2 <= wr_ready_d;
        wr_ready_d  <= wr_ready;
        wr_valid_d  <= wr_valid;
        if (!rst && wr_valid && (wr_ready_d || wr_ready_d2)) begin
            proto_err <= proto_err + 1;
        end
        if (rst) begin
            hi_cnt <= 1000;
        end else if (spi_cs != '1) begin
            hi_cnt <= 0;
        end else if (hi_cnt < 1000) begin
            hi_cnt <= hi_cnt + 1;
        end
        if (!rst && wr_valid && !wr_valid_d && hi_cnt < CS_GAP) begin
            gap_err <= gap_err + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] ch, input logic [15:0] d, input logic rd);
        cmd_valid = 1'b1;
        cmd_chan  = ch;
        cmd_data  = d;
        cmd_rd    = rd;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output bit got);
        got = rsp_valid;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = rsp_valid;
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = !busy;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = !busy;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL idle_wait: busy=%b after %0d cycles, required 0", busy, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_cmd_ready: got %b required 1", cmd_ready);
        end
        checks++;
        if ({wr_valid, rsp_valid, rsp_tmo, busy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b required 0000", {wr_valid, rsp_valid, rsp_tmo, busy});
        end
        checks++;
        if ({wr_channel, data_in, rsp_data, rsp_chan} !== 43'd0) begin
            errors++;
            $display("[TB] FAIL reset_buses: got %h required 0", {wr_channel, data_in, rsp_data, rsp_chan});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        int base;
        bit got;
        logic [7:0]  cs_seen;
        logic [15:0] mosi_seen;
        base = cs_log.size();
        push_cmd(3'd2, 16'hA55A, 1'b1);
        checks++;
        if (wr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL latency_early: wr_valid=%b one cycle after push, required 0", wr_valid);
        end
        tick();
        checks++;
        if (wr_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL latency: wr_valid=%b two cycles after push, required 1", wr_valid);
        end
        checks++;
        if (wr_channel !== 8'h04 || data_in !== 16'hA55A) begin
            errors++;
            $display("[TB] FAIL req_fields: chan=%h data=%h required 04/a55a", wr_channel, data_in);
        end
        wait_rsp(200, got);
        checks++;
        if (!got || rsp_data !== 16'hA55A || rsp_chan !== 3'd2 || rsp_tmo !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_rsp: valid=%b data=%h chan=%0d tmo=%b required 1/a55a/2/0",
                     rsp_valid, rsp_data, rsp_chan, rsp_tmo);
        end
        cs_seen   = (cs_log.size() > base) ? cs_log[base] : 8'h00;
        mosi_seen = (mosi_log.size() > base) ? mosi_log[base] : 16'h0000;
        checks++;
        if (cs_seen !== 8'hFB || mosi_seen !== 16'hA55A) begin
            errors++;
            $display("[TB] FAIL single_bus: cs=%h mosi=%h required fb/a55a", cs_seen, mosi_seen);
        end
        consume();
        wait_idle(50);
    endtask

    task automatic test_fifo_full_order();
        int accepted;
        int base;
        bit got;
        logic [2:0]  exp_chan;
        logic [15:0] exp_data;
        logic [7:0]  exp_cs;
        logic [7:0]  cs_seen;
        base = cs_log.size();
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            if (!cmd_ready) break;
            push_cmd(3'(i % 8), 16'(16'hC000 + i), 1'b1);
            accepted++;
        end
        checks++;
        if (accepted !== 9 || cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fifo_full: accepted=%0d cmd_ready=%b required 9/0", accepted, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_chan  = 3'd0;
        cmd_data  = 16'hDEAD;
        cmd_rd    = 1'b1;
        tick();
        tick();
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp_chan = 3'(i % 8);
            exp_data = 16'(16'hC000 + i);
            exp_cs   = ~(8'd1 << exp_chan);
            wait_rsp(300, got);
            checks++;
            if (!got || rsp_data !== exp_data || rsp_chan !== exp_chan) begin
                errors++;
                $display("[TB] FAIL order_rsp%0d: valid=%b data=%h chan=%0d required 1/%h/%0d",
                         i, rsp_valid, rsp_data, rsp_chan, exp_data, exp_chan);
            end
            cs_seen = (cs_log.size() > base + i) ? cs_log[base + i] : 8'h00;
            checks++;
            if (cs_seen !== exp_cs) begin
                errors++;
                $display("[TB] FAIL order_cs%0d: got %h required %h", i, cs_seen, exp_cs);
            end
            consume();
        end
        wait_idle(50);
        checks++;
        if (cs_log.size() - base !== 9) begin
            errors++;
            $display("[TB] FAIL no_overwrite: transfers=%0d required 9", cs_log.size() - base);
        end
    endtask

    task automatic test_rd_filter();
        int base;
        int extra;
        bit got;
        base = cs_log.size();
        push_cmd(3'd1, 16'h1111, 1'b0);
        push_cmd(3'd5, 16'h2222, 1'b1);
        wait_rsp(300, got);
        checks++;
        if (!got || rsp_chan !== 3'd5 || rsp_data !== 16'h2222) begin
            errors++;
            $display("[TB] FAIL rd_filter_rsp: valid=%b chan=%0d data=%h required 1/5/2222",
                     rsp_valid, rsp_chan, rsp_data);
        end
        consume();
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (rsp_valid) extra++;
        end
        checks++;
        if (extra !== 0 || cs_log.size() - base !== 2) begin
            errors++;
            $display("[TB] FAIL rd_filter_count: extra_rsp_cycles=%0d transfers=%0d required 0/2",
                     extra, cs_log.size() - base);
        end
        wait_idle(50);
    endtask

    task automatic test_timeout();
        int n;
        int cyc;
        accept_only = 1'b1;
        push_cmd(3'd3, 16'hBEEF, 1'b0);
        n = 0;
        while (!wr_valid && n < 20) begin
            tick();
            n++;
        end
        while (wr_valid && n < 40) begin
            tick();
            n++;
        end
        cyc = 0;
        while (!rsp_valid && cyc < TIMEOUT + 100) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== TIMEOUT) begin
            errors++;
            $display("[TB] FAIL timeout_cycles: rsp_valid after %0d cycles, required %0d", cyc, TIMEOUT);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_tmo !== 1'b1 || rsp_data !== 16'h0000 || rsp_chan !== 3'd3) begin
            errors++;
            $display("[TB] FAIL timeout_rsp: valid=%b tmo=%b data=%h chan=%0d required 1/1/0000/3",
                     rsp_valid, rsp_tmo, rsp_data, rsp_chan);
        end
        consume();
        accept_only = 1'b0;
        wait_idle(50);
    endtask

    task automatic test_backpressure();
        bit got;
        int unstable;
        int req_seen;
        bit ready_a;
        bit ready_b;
        push_cmd(3'd6, 16'h0F0F, 1'b1);
        wait_rsp(300, got);
        checks++;
        if (!got || rsp_data !== 16'h0F0F || rsp_chan !== 3'd6) begin
            errors++;
            $display("[TB] FAIL bp_first: valid=%b data=%h chan=%0d required 1/0f0f/6", rsp_valid, rsp_data, rsp_chan);
        end
        ready_a = cmd_ready;
        push_cmd(3'd0, 16'h1234, 1'b1);
        ready_b = cmd_ready;
        push_cmd(3'd7, 16'h8765, 1'b0);
        checks++;
        if (ready_a !== 1'b1 || ready_b !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_accept: ready=%b%b busy=%b required 11/1", ready_a, ready_b, busy);
        end
        unstable = 0;
        req_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h0F0F || rsp_chan !== 3'd6 || rsp_tmo !== 1'b0) unstable++;
            if (wr_valid) req_seen++;
        end
        checks++;
        if (unstable !== 0 || req_seen !== 0) begin
            errors++;
            $display("[TB] FAIL bp_stall: unstable_cycles=%0d wr_valid_cycles=%0d required 0/0", unstable, req_seen);
        end
        consume();
        wait_rsp(300, got);
        checks++;
        if (!got || rsp_data !== 16'h1234 || rsp_chan !== 3'd0) begin
            errors++;
            $display("[TB] FAIL bp_next: valid=%b data=%h chan=%0d required 1/1234/0", rsp_valid, rsp_data, rsp_chan);
        end
        consume();
        wait_idle(200);
    endtask

    task automatic test_reset_mid_transfer();
        int n;
        int req_seen;
        push_cmd(3'd4, 16'h5A5A, 1'b1);
        push_cmd(3'd1, 16'h7777, 1'b1);
        n = 0;
        while (spi_cs == 8'hFF && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (spi_cs !== 8'hEF) begin
            errors++;
            $display("[TB] FAIL mid_cs_low: spi_cs=%h required ef", spi_cs);
        end
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || wr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: busy=%b wr_valid=%b required 0/0", busy, wr_valid);
        end
        tick();
        checks++;
        if ({wr_valid, rsp_valid, cmd_ready, busy} !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL mid_reset: wr_valid/rsp_valid/cmd_ready/busy=%b required 0010",
                     {wr_valid, rsp_valid, cmd_ready, busy});
        end
        rst = 1'b0;
        req_seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (wr_valid || busy) req_seen++;
        end
        checks++;
        if (req_seen !== 0) begin
            errors++;
            $display("[TB] FAIL flush_after_reset: active_cycles=%0d required 0", req_seen);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (proto_err !== 0) begin
            errors++;
            $display("[TB] FAIL wr_valid_after_ready: violations=%0d required 0", proto_err);
        end
        checks++;
        if (gap_err !== 0) begin
            errors++;
            $display("[TB] FAIL cs_gap: violations=%0d required 0", gap_err);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_chan  = '0;
        cmd_data  = '0;
        cmd_rd    = 1'b0;
        rsp_ready = 1'b0;
        test_reset();
        test_single_read();
        test_fifo_full_order();
        test_rd_filter();
        test_timeout();
        test_backpressure();
        test_reset_mid_transfer();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
